// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around one 1-bit full-adder cell.
// Ports: clk, rst_n (async low), start, a, b, cin -> busy, done, sum, cout, ovf.

// 1-bit full-adder cell: a, b, carry-in c -> sum f, carry-out cplus.
module adder_module (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic f,
    output logic cplus
);
    assign f     = a ^ b ^ c;
    assign cplus = (a & b) | (a & c) | (b & c);
endmodule

// Sequencer: one operand bit pair per clock, LSB first, into adder_module.
// busy/done are decodes of state; sum/cout/ovf update on the final RUN edge.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    // Sized so WIDTH-1 fits; the counter never wraps inside a run.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_f;
    logic             w_cplus;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    adder_module u_cell (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .c     (r_carry),
        .f     (w_f),
        .cplus (w_cplus)
    );

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_s_next = {w_f, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_s_sh  <= w_s_next;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry <= w_cplus;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_cplus;
                        // Carry into the MSB differs from carry out of it.
                        r_ovf   <= r_carry ^ w_cplus;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
